// File: rtl/spike_rr_extractor.sv
// Spike-train to RR-interval extractor: measures prescaled ticks between accepted
// spike rising edges and emits each interval with a one-cycle NR strobe.
module spike_rr_extractor #(
  parameter int unsigned W        = 18,
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned MIN_RR   = 4,
  parameter int unsigned MAX_RR   = 2**18 - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         spike,
  output logic [W-1:0] RR,
  output logic         NR,
  output logic         tmo
);

  localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [W-1:0]  CNT_MAX    = W'(MAX_RR);
  localparam logic [W-1:0]  CNT_MIN    = W'(MIN_RR);

  typedef enum logic {
    IDLE,
    COUNT
  } state_e;

  state_e        state_q, state_d;
  logic          spike_prev_q, spike_prev_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  count_q, count_d;
  logic [W-1:0]  rr_q, rr_d;
  logic          nr_q, nr_d;
  logic          tmo_q, tmo_d;
  logic          edge_det;
  logic          tick;
  logic [W-1:0]  count_inc;

  always_comb begin
    spike_prev_d = spike;
    edge_det     = spike & ~spike_prev_q;
    tick         = (state_q == COUNT) && (presc_q == PRESC_LAST);
    // Interval value as it stands at the end of this cycle, including a same-cycle tick.
    count_inc    = (tick && (count_q != CNT_MAX)) ? count_q + 1'b1 : count_q;

    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    rr_d    = rr_q;
    nr_d    = 1'b0;
    tmo_d   = 1'b0;

    if (!en) begin
      state_d = IDLE;
      presc_d = '0;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          presc_d = '0;
          count_d = '0;
          if (edge_det) state_d = COUNT;
        end
        COUNT: begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          count_d = count_inc;
          if (edge_det && (count_inc >= CNT_MIN)) begin
            rr_d    = count_inc;
            nr_d    = 1'b1;
            presc_d = '0;
            count_d = '0;
          end else if (count_inc == CNT_MAX) begin
            tmo_d   = 1'b1;
            state_d = IDLE;
            presc_d = '0;
            count_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      spike_prev_q <= 1'b1;
      presc_q      <= '0;
      count_q      <= '0;
      rr_q         <= '0;
      nr_q         <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      spike_prev_q <= spike_prev_d;
      presc_q      <= presc_d;
      count_q      <= count_d;
      rr_q         <= rr_d;
      nr_q         <= nr_d;
      tmo_q        <= tmo_d;
    end
  end

  assign RR  = rr_q;
  assign NR  = nr_q;
  assign tmo = tmo_q;

endmodule

// File: tb/tb_spike_rr_extractor.sv
// Directed bench for spike_rr_extractor: one instance at TICK_DIV=1/MAX_RR=1000,
// one at TICK_DIV=10 with default timeout.
module tb_spike_rr_extractor;

  logic        clk;
  logic        rst;
  logic        en;
  logic        spike_a, spike_b;
  logic [17:0] rr_a, rr_b;
  logic        nr_a, nr_b, tmo_a, tmo_b;

  int n_checks = 0;
  int n_errors = 0;
  int nr_cnt_a, tmo_cnt_a, nr_cnt_b, tmo_cnt_b, b2b_cnt;
  logic nr_prev_a, nr_prev_b;
  int tmo_at;

  spike_rr_extractor #(
    .W(18), .TICK_DIV(1), .MIN_RR(4), .MAX_RR(1000)
  ) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .spike(spike_a),
    .RR(rr_a), .NR(nr_a), .tmo(tmo_a)
  );

  spike_rr_extractor #(
    .W(18), .TICK_DIV(10), .MIN_RR(4), .MAX_RR(2**18 - 1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .spike(spike_b),
    .RR(rr_b), .NR(nr_b), .tmo(tmo_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic adv();
    @(posedge clk);
    #1;
    if (nr_a) nr_cnt_a++;
    if (tmo_a) tmo_cnt_a++;
    if (nr_b) nr_cnt_b++;
    if (tmo_b) tmo_cnt_b++;
    if ((nr_a && nr_prev_a) || (nr_b && nr_prev_b)) b2b_cnt++;
    nr_prev_a = nr_a;
    nr_prev_b = nr_b;
  endtask

  task automatic set_spike(input bit sel_b, input logic v);
    if (sel_b) spike_b = v;
    else       spike_a = v;
  endtask

  task automatic clear_counts();
    nr_cnt_a = 0; tmo_cnt_a = 0; nr_cnt_b = 0; tmo_cnt_b = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b1; spike_a = 1'b0; spike_b = 1'b0;
    repeat (3) adv();
    rst = 1'b1;
    adv();
    clear_counts();
  endtask

  // Rising edge sampled on the next clock.
  task automatic ref_edge(input bit sel_b);
    set_spike(sel_b, 1'b0);
    adv();
    set_spike(sel_b, 1'b1);
    adv();
  endtask

  // Next rising edge exactly n cycles after the previous one.
  task automatic edge_after(input bit sel_b, input int n);
    set_spike(sel_b, 1'b0);
    repeat (n - 1) adv();
    set_spike(sel_b, 1'b1);
    adv();
  endtask

  initial begin
    b2b_cnt = 0; nr_prev_a = 1'b0; nr_prev_b = 1'b0;
    clear_counts();

    // Reset state
    rst = 1'b0; en = 1'b1; spike_a = 1'b0; spike_b = 1'b0;
    repeat (3) adv();
    check_eq("rst_rr", rr_a, 0);
    check_eq("rst_nr", nr_a, 0);
    check_eq("rst_tmo", tmo_a, 0);
    check_eq("rst_rr_b", rr_b, 0);

    // Edges at 50 and 150: only the second produces NR
    rst = 1'b1;
    clear_counts();
    repeat (49) adv();
    spike_a = 1'b1;
    adv();
    check_eq("s1_ref_nr", nr_a, 0);
    edge_after(0, 100);
    check_eq("s1_nr", nr_a, 1);
    check_eq("s1_rr", rr_a, 100);
    adv();
    check_eq("s1_nr_width", nr_a, 0);
    check_eq("s1_rr_hold", rr_a, 100);
    check_eq("s1_nr_cnt", nr_cnt_a, 1);

    // Spike held high across reset release is not an edge
    rst = 1'b0; spike_a = 1'b1;
    repeat (3) adv();
    rst = 1'b1;
    clear_counts();
    repeat (20) adv();
    check_eq("s2_no_event_nr", nr_cnt_a, 0);
    check_eq("s2_no_event_tmo", tmo_cnt_a, 0);
    spike_a = 1'b0;
    repeat (40) adv();
    spike_a = 1'b1;
    adv();
    check_eq("s2_ref_nr", nr_a, 0);
    edge_after(0, 100);
    check_eq("s2_nr", nr_a, 1);
    check_eq("s2_rr", rr_a, 100);
    check_eq("s2_nr_cnt", nr_cnt_a, 1);

    // Glitch inside the refractory window does not restart the count
    do_reset();
    ref_edge(0);
    edge_after(0, 2);
    check_eq("s3_glitch_nr", nr_a, 0);
    edge_after(0, 248);
    check_eq("s3_nr", nr_a, 1);
    check_eq("s3_rr", rr_a, 250);
    check_eq("s3_nr_cnt", nr_cnt_a, 1);

    // Timeout at MAX_RR, next edge is only a reference
    do_reset();
    ref_edge(0);
    spike_a = 1'b0;
    tmo_at = -1;
    for (int i = 1; i <= 1499; i++) begin
      adv();
      if (tmo_a) tmo_at = i;
    end
    check_eq("s4_tmo_cnt", tmo_cnt_a, 1);
    check_eq("s4_tmo_at", tmo_at, 1000);
    check_eq("s4_rr_kept", rr_a, 0);
    spike_a = 1'b1;
    adv();
    check_eq("s4_ref_nr", nr_a, 0);
    edge_after(0, 100);
    check_eq("s4_nr", nr_a, 1);
    check_eq("s4_rr", rr_a, 100);
    check_eq("s4_nr_cnt", nr_cnt_a, 1);

    // Edge landing on the MAX_RR cycle wins over the timeout
    do_reset();
    ref_edge(0);
    edge_after(0, 1000);
    check_eq("s4b_nr", nr_a, 1);
    check_eq("s4b_rr", rr_a, 1000);
    check_eq("s4b_tmo", tmo_a, 0);
    repeat (5) adv();
    check_eq("s4b_tmo_cnt", tmo_cnt_a, 0);

    // TICK_DIV=10, edges 1000 cycles apart
    do_reset();
    ref_edge(1);
    check_eq("s5_ref_nr", nr_b, 0);
    for (int k = 0; k < 4; k++) begin
      edge_after(1, 1000);
      check_eq("s5_nr", nr_b, 1);
      check_eq("s5_rr", rr_b, 100);
    end
    check_eq("s5_nr_cnt", nr_cnt_b, 4);
    check_eq("s5_tmo_cnt", tmo_cnt_b, 0);

    // Reset mid-interval discards it and clears RR
    do_reset();
    ref_edge(0);
    edge_after(0, 50);
    check_eq("s6_pre_rr", rr_a, 50);
    spike_a = 1'b0;
    repeat (39) adv();
    rst = 1'b0;
    repeat (20) adv();
    check_eq("s6_rst_rr", rr_a, 0);
    check_eq("s6_rst_nr_cnt", nr_cnt_a, 1);
    rst = 1'b1;
    repeat (20) adv();
    spike_a = 1'b1;
    adv();
    check_eq("s6_ref_nr", nr_a, 0);
    edge_after(0, 120);
    check_eq("s6_nr", nr_a, 1);
    check_eq("s6_rr", rr_a, 120);

    // en=0 mid-interval: edges ignored, RR retained
    do_reset();
    ref_edge(0);
    edge_after(0, 50);
    spike_a = 1'b0;
    repeat (39) adv();
    en = 1'b0;
    repeat (10) adv();
    spike_a = 1'b1;
    adv();
    spike_a = 1'b0;
    repeat (9) adv();
    check_eq("s6b_en_rr", rr_a, 50);
    check_eq("s6b_en_nr_cnt", nr_cnt_a, 1);
    en = 1'b1;
    repeat (20) adv();
    spike_a = 1'b1;
    adv();
    check_eq("s6b_ref_nr", nr_a, 0);
    check_eq("s6b_ref_rr", rr_a, 50);
    edge_after(0, 120);
    check_eq("s6b_nr", nr_a, 1);
    check_eq("s6b_rr", rr_a, 120);
    check_eq("s6b_nr_cnt", nr_cnt_a, 2);

    check_eq("nr_back_to_back", b2b_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
